// File: rtl/blk_chan_fifo.sv
// Channel end of a blocking notify/sync handshake: a DEPTH-entry FIFO with
// registered head-of-buffer output and a consumer-side transfer counter.
module blk_chan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_notify,
  output logic                       in_sync,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_notify,
  output logic                       out_sync,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                xfer_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      xfer_cnt_q, xfer_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             push, pop;

  // Handshake outputs depend on registered occupancy only.
  assign in_sync  = (count_q != FULL_CNT);
  assign out_sync = (count_q != '0);
  assign out_data = out_data_q;
  assign count    = count_q;
  assign xfer_cnt = xfer_cnt_q;

  always_comb begin
    push       = in_notify & in_sync;
    pop        = out_notify & out_sync;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    out_data_d = out_data_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      xfer_cnt_d = xfer_cnt_q + 32'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The next head is the incoming word when the buffer is (or is about to
    // be) emptied of older entries; otherwise it is already in storage.
    if (count_d != '0) begin
      if (push && ((count_q == '0) || ((count_q == CW'(1)) && pop)))
        out_data_d = in_data;
      else
        out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: out_sync gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
